// File: rtl/oflow_sched_pkg.sv
// Shared types for the optical-flow similarity scheduler: FSM state encoding and score ceiling.
package oflow_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        RUN,
        FINISH
    } sched_state_t;

    localparam logic [63:0] SCORE_MAX = '1;

endpackage

// File: rtl/oflow_min_tracker.sv
// Running minimum of metric scores with the id that produced it; earlier candidates win ties.
module oflow_min_tracker
    import oflow_sched_pkg::*;
#(
    parameter int SCORE_W = 32,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               clr,
    input  logic               upd,
    input  logic [SCORE_W-1:0] score,
    input  logic [ID_W-1:0]    id,
    output logic [SCORE_W-1:0] best_score,
    output logic [ID_W-1:0]    best_id
);

    logic [SCORE_W-1:0] best_score_q;
    logic [ID_W-1:0]    best_id_q;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            best_score_q <= SCORE_MAX[SCORE_W-1:0];
            best_id_q    <= '0;
        end else if (clr) begin
            best_score_q <= SCORE_MAX[SCORE_W-1:0];
            best_id_q    <= '0;
        end else if (upd && (score < best_score_q)) begin
            best_score_q <= score;
            best_id_q    <= id;
        end
    end

    assign best_score = best_score_q;
    assign best_id    = best_id_q;

endmodule

// File: rtl/oflow_similarity_scheduler.sv
// Scans one current-frame object against N previous-frame feature lines through a single
// similarity metric, prefetching the next line on the metric's hint, and reports the best match.
module oflow_similarity_scheduler
    import oflow_sched_pkg::*;
#(
    parameter int FEAT_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int SCORE_W = 32,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic [ADDR_W-1:0]  num_prev_objs,
    input  logic [SCORE_W-1:0] score_threshold,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [FEAT_W-1:0]  rd_data,
    output logic [FEAT_W-1:0]  features_of_prev,
    output logic               sim_start,
    input  logic               sim_read_new_line,
    input  logic               sim_valid,
    input  logic [SCORE_W-1:0] sim_score,
    input  logic [ID_W-1:0]    sim_id,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] best_score,
    output logic [ID_W-1:0]    best_id,
    output logic               match_found
);

    sched_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d, count_q, count_d;
    logic [SCORE_W-1:0] thr_q, thr_d;
    logic [FEAT_W-1:0]  active_q, active_d, pf_line_q, pf_line_d;
    logic               pf_valid_q, pf_valid_d;
    logic               pf_pend_q, pf_pend_d;
    logic               pf_taken_q, pf_taken_d;
    logic               match_q, match_d;
    logic [ADDR_W:0]    idx_nxt;
    logic               has_next, match_now, trk_clr, trk_upd;

    // One extra bit so a full-range count never wraps the last-candidate test.
    assign idx_nxt   = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign has_next  = idx_nxt < {1'b0, count_q};
    assign match_now = (count_q != '0) && (best_score <= thr_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        thr_d      = thr_q;
        active_d   = active_q;
        pf_line_d  = pf_line_q;
        pf_valid_d = pf_valid_q;
        pf_pend_d  = 1'b0;
        pf_taken_d = pf_taken_q;
        match_d    = match_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
        sim_start  = 1'b0;
        done       = 1'b0;
        trk_clr    = 1'b0;
        trk_upd    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = num_prev_objs;
                    thr_d      = score_threshold;
                    idx_d      = '0;
                    match_d    = 1'b0;
                    pf_valid_d = 1'b0;
                    pf_taken_d = 1'b0;
                    trk_clr    = 1'b1;
                    state_d    = (num_prev_objs == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = idx_q;
                state_d = LOAD;
            end
            LOAD: begin
                active_d   = rd_data;
                pf_valid_d = 1'b0;
                pf_taken_d = 1'b0;
                state_d    = ISSUE;
            end
            ISSUE: begin
                sim_start = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                // A hint coinciding with the result is dropped; the fallback fetch covers it.
                if (sim_read_new_line && has_next && !pf_taken_q && !sim_valid) begin
                    rd_en      = 1'b1;
                    rd_addr    = idx_nxt[ADDR_W-1:0];
                    pf_pend_d  = 1'b1;
                    pf_taken_d = 1'b1;
                end
                if (pf_pend_q) begin
                    pf_line_d  = rd_data;
                    pf_valid_d = 1'b1;
                end
                if (sim_valid) begin
                    trk_upd = 1'b1;
                    if (!has_next) begin
                        state_d = FINISH;
                    end else begin
                        idx_d      = idx_nxt[ADDR_W-1:0];
                        pf_taken_d = 1'b0;
                        pf_valid_d = 1'b0;
                        if (pf_valid_q) begin
                            active_d = pf_line_q;
                            state_d  = ISSUE;
                        end else if (pf_pend_q) begin
                            active_d = rd_data;
                            state_d  = ISSUE;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                match_d = match_now;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            thr_q      <= '0;
            active_q   <= '0;
            pf_line_q  <= '0;
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
            pf_taken_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            thr_q      <= thr_d;
            active_q   <= active_d;
            pf_line_q  <= pf_line_d;
            pf_valid_q <= pf_valid_d;
            pf_pend_q  <= pf_pend_d;
            pf_taken_q <= pf_taken_d;
            match_q    <= match_d;
        end
    end

    oflow_min_tracker #(
        .SCORE_W (SCORE_W),
        .ID_W    (ID_W)
    ) u_min_tracker (
        .clk        (clk),
        .reset_N    (reset_N),
        .clr        (trk_clr),
        .upd        (trk_upd),
        .score      (sim_score),
        .id         (sim_id),
        .best_score (best_score),
        .best_id    (best_id)
    );

    assign features_of_prev = active_q;
    assign busy             = (state_q != IDLE) && (state_q != FINISH);
    assign match_found      = (state_q == FINISH) ? match_now : match_q;

endmodule
